// File: rtl/note_recorder_pkg.sv
// Shared track-entry format and helpers for the recorder, song ROM and player.
package note_recorder_pkg;

    localparam int NUM_KEYS = 7;
    localparam int OCT_W    = 3;
    localparam int NOTE_W   = 3;
    localparam int LEN_W    = 4;
    localparam int ENTRY_W  = OCT_W + NOTE_W + LEN_W;

    localparam int LEN_LSB  = 0;
    localparam int NOTE_LSB = LEN_LSB + LEN_W;
    localparam int OCT_LSB  = NOTE_LSB + NOTE_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    localparam int MAX_LEN = 15;

    typedef struct packed {
        logic [OCT_W-1:0]  oct;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  len;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD, S_FULL} rec_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [OCT_W-1:0]  oct,
                                                      input logic [NOTE_W-1:0] note,
                                                      input logic [LEN_W-1:0]  len);
        return {oct, note, len};
    endfunction

    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        return entry_t'(raw);
    endfunction

    // Lowest pressed key wins; nothing pressed is a rest.
    function automatic logic [NOTE_W-1:0] key_to_note(input logic [NUM_KEYS-1:0] k);
        logic [NOTE_W-1:0] n;
        n = NOTE_REST;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (k[i]) n = NOTE_W'(i + 1);
        return n;
    endfunction

    function automatic logic [NUM_KEYS-1:0] note_to_onehot(input logic [NOTE_W-1:0] n);
        logic [NUM_KEYS-1:0] oh;
        oh = '0;
        if (n != NOTE_REST) oh[n - 1'b1] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/note_recorder_key_debounce.sv
// Two-flop synchroniser followed by a stability filter on the whole key vector.
module key_debounce
    import note_recorder_pkg::*;
#(
    parameter int W              = NUM_KEYS,
    parameter int DEBOUNCE_TICKS = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [W-1:0]  sync1, sync2, cand;
    logic [CW-1:0] cnt;

    // Any change restarts the count; the candidate is only accepted once it has
    // survived DEBOUNCE_TICKS consecutive cycles unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                stable <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Records debounced key presses as {octave, note, length} entries into a track RAM.
module note_recorder #(
    parameter int DEPTH          = 64,
    parameter int BEAT_TICKS     = 25_000_000,
    parameter int DEBOUNCE_TICKS = 1_000_000,
    parameter int MAX_LEN        = 15,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [6:0]    key,
    input  logic [2:0]    octave,
    input  logic [AW-1:0] rd_addr,
    output logic [9:0]    rd_data,
    output logic [AW:0]   track_len,
    output logic          full,
    output logic [6:0]    led
);

    import note_recorder_pkg::*;

    localparam int CW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

    logic [NUM_KEYS-1:0] key_db;

    key_debounce #(.W(NUM_KEYS), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key),
        .stable(key_db)
    );

    rec_state_t        state;
    logic              en_q;
    logic [OCT_W-1:0]  held_oct;
    logic [NOTE_W-1:0] held_note;
    logic [CW-1:0]     cyc;
    logic [LEN_W-1:0]  units;

    logic [NOTE_W-1:0]  cur_note;
    logic [OCT_W-1:0]   cur_oct;
    logic               start, changed, tick, sat, wr_en, wr_fill;
    logic [LEN_W-1:0]   units_n, eff_len;
    logic [ENTRY_W-1:0] wr_data;

    assign cur_note = key_to_note(key_db);
    assign cur_oct  = (cur_note == NOTE_REST) ? '0 : octave;
    assign start    = en && !en_q;
    assign changed  = {cur_oct, cur_note} != {held_oct, held_note};

    // The commit edge itself counts as a held cycle, so the length is the
    // post-increment unit count.
    assign tick    = (cyc == CW'(BEAT_TICKS - 1));
    assign units_n = units + LEN_W'(tick);
    assign sat     = tick && (units == LEN_W'(MAX_LEN - 1));
    assign eff_len = (units_n == '0) ? LEN_W'(1) : units_n;
    assign wr_data = pack_entry(held_oct, held_note, eff_len);
    assign wr_fill = wr_en && (track_len == (AW+1)'(DEPTH - 1));

    // Decide whether the held symbol is written this cycle.
    always_comb begin
        wr_en = 1'b0;
        if (state == S_HOLD) begin
            if (!en)                 wr_en = (held_note != NOTE_REST);
            else if (changed || sat) wr_en = 1'b1;
        end
    end

    // Recording FSM: arm on the enable edge, track hold time, commit entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            en_q      <= 1'b1;  // an enable held through reset must not start a recording
            held_oct  <= '0;
            held_note <= NOTE_REST;
            cyc       <= '0;
            units     <= '0;
            track_len <= '0;
            full      <= 1'b0;
            led       <= '0;
        end else begin
            en_q <= en;
            unique case (state)
                S_IDLE: begin
                    led <= '0;
                    if (start) begin
                        track_len <= '0;
                        full      <= 1'b0;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (cur_note != NOTE_REST) begin
                        held_oct  <= cur_oct;
                        held_note <= cur_note;
                        cyc       <= '0;
                        units     <= '0;
                        led       <= note_to_onehot(cur_note);
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (wr_en) track_len <= track_len + 1'b1;
                    if (wr_fill) begin
                        full  <= 1'b1;
                        led   <= '0;
                        state <= S_FULL;
                    end else if (!en) begin
                        led   <= '0;
                        state <= S_IDLE;
                    end else if (changed) begin
                        held_oct  <= cur_oct;
                        held_note <= cur_note;
                        cyc       <= '0;
                        units     <= '0;
                        led       <= note_to_onehot(cur_note);
                    end else if (sat) begin
                        cyc   <= '0;
                        units <= '0;
                    end else begin
                        cyc   <= tick ? '0 : cyc + 1'b1;
                        units <= units_n;
                    end
                end
                S_FULL: begin
                    led <= '0;
                    if (start) begin
                        track_len <= '0;
                        full      <= 1'b0;
                        state     <= S_ARM;
                    end else if (!en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Track RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[track_len[AW-1:0]] <= wr_data;
    end

    // Registered read port; a same-cycle write to rd_addr returns the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_note_recorder.sv
// Table-driven bench for note_recorder with a scoreboard of expected track entries.
module tb_note_recorder;

    localparam int DEPTH = 8;
    localparam int BT    = 4;
    localparam int DT    = 2;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n, en;
    logic [6:0]    key;
    logic [2:0]    octave;
    logic [AW-1:0] rd_addr;
    logic [9:0]    rd_data;
    logic [AW:0]   track_len;
    logic          full;
    logic [6:0]    led;

    always #5 clk = ~clk;

    note_recorder #(.DEPTH(DEPTH), .BEAT_TICKS(BT), .DEBOUNCE_TICKS(DT), .MAX_LEN(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .key      (key),
        .octave   (octave),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .track_len(track_len),
        .full     (full),
        .led      (led)
    );

    typedef struct packed {
        logic [2:0]       oct;
        logic [3:0]       nseg;
        logic [9:0][6:0]  k;
        logic [9:0][7:0]  n;
        logic [3:0]       nexp;
        logic [7:0][9:0]  ex;
        logic             exp_full;
    } vec_t;

    localparam int NCASE = 6;
    vec_t       tbl [NCASE];
    logic [9:0] sb [$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_seg(input int c, input logic [6:0] kk, input int n);
        tbl[c].k[tbl[c].nseg] = kk;
        tbl[c].n[tbl[c].nseg] = 8'(n);
        tbl[c].nseg           = tbl[c].nseg + 1'b1;
    endtask

    task automatic add_exp(input int c, input int o, input int nt, input int l);
        tbl[c].ex[tbl[c].nexp] = {3'(o), 3'(nt), 4'(l)};
        tbl[c].nexp            = tbl[c].nexp + 1'b1;
    endtask

    function automatic logic [6:0] lowbit(input logic [6:0] k);
        return k & (~k + 7'd1);
    endfunction

    task automatic wait_led(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (led != '0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_case(input int c);
        vec_t v;
        logic [9:0] exp;
        v = tbl[c];
        for (int i = 0; i < int'(v.nexp); i++) sb.push_back(v.ex[i]);
        key = '0; en = 1'b0; octave = v.oct;
        repeat (10) @(negedge clk);
        en = 1'b1;
        for (int s = 0; s < int'(v.nseg); s++) begin
            key = v.k[s];
            repeat (int'(v.n[s])) @(negedge clk);
            if (v.n[s] >= 8)
                check($sformatf("case%0d led seg%0d", c, s), 32'(led), 32'(lowbit(v.k[s])));
        end
        key = '0;
        repeat (12) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check($sformatf("case%0d track_len", c), 32'(track_len), 32'(v.nexp));
        check($sformatf("case%0d full", c), 32'(full), 32'(v.exp_full));
        for (int i = 0; i < int'(v.nexp); i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            exp = sb.pop_front();
            check($sformatf("case%0d entry%0d", c, i), 32'(rd_data), 32'(exp));
        end
    endtask

    initial begin
        for (int c = 0; c < NCASE; c++) tbl[c] = '0;
        // two notes
        tbl[0].oct = 3'd3;
        add_seg(0, 7'b0000001, 12); add_seg(0, 7'b0000100, 5);
        add_exp(0, 3, 1, 3); add_exp(0, 3, 3, 1);
        // leading rest dropped, inner rest kept with octave 0
        tbl[1].oct = 3'd5;
        add_seg(1, 7'b0000000, 6); add_seg(1, 7'b0000001, 8);
        add_seg(1, 7'b0000000, 9); add_seg(1, 7'b0010000, 4);
        add_exp(1, 5, 1, 2); add_exp(1, 0, 0, 2); add_exp(1, 5, 5, 1);
        // saturation split
        tbl[2].oct = 3'd2;
        add_seg(2, 7'b0000010, 70);
        add_exp(2, 2, 2, 15); add_exp(2, 2, 2, 2);
        // two keys together: lowest wins
        tbl[3].oct = 3'd4;
        add_seg(3, 7'b0100001, 10);
        add_exp(3, 4, 1, 2);
        // single-cycle bounces are filtered out
        tbl[4].oct = 3'd7;
        add_seg(4, 7'b0000001, 6); add_seg(4, 7'b0000000, 1); add_seg(4, 7'b0000001, 6);
        add_seg(4, 7'b0001000, 1); add_seg(4, 7'b0000001, 6);
        add_exp(4, 7, 1, 5);
        // overflow: 9 notes, only DEPTH stored
        tbl[5].oct = 3'd1;
        for (int i = 0; i < 9; i++) add_seg(5, (i % 2) ? 7'b0000010 : 7'b0000001, 4);
        for (int i = 0; i < 8; i++) add_exp(5, 1, (i % 2) + 1, 1);
        tbl[5].exp_full = 1'b1;

        rst_n = 1'b0; en = 1'b0; key = '0; octave = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset track_len", 32'(track_len), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset led", 32'(led), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);

        // reset in the middle of HOLD with enable still high
        octave = 3'd3; key = 7'b0000001;
        @(negedge clk); en = 1'b1;
        wait_led("reach hold before reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midhold reset track_len", 32'(track_len), 32'd0);
        check("midhold reset full", 32'(full), 32'd0);
        check("midhold reset led", 32'(led), 32'd0);
        check("midhold reset rd_data", 32'(rd_data), 32'd0);
        repeat (20) @(negedge clk);
        check("stay idle led", 32'(led), 32'd0);
        check("stay idle track_len", 32'(track_len), 32'd0);
        en = 1'b0; @(negedge clk);
        en = 1'b1;
        wait_led("rearm after toggle");
        check("rearm led", 32'(led), 32'h01);
        en = 1'b0; key = '0;
        repeat (10) @(negedge clk);

        for (int c = 0; c < NCASE; c++) run_case(c);

        // new recording clears full and length; RAM keeps old entries
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("restart full", 32'(full), 32'd0);
        check("restart track_len", 32'(track_len), 32'd0);
        rd_addr = 3'd7;
        @(negedge clk);
        check("ram kept entry7", 32'(rd_data), 32'({3'd1, 3'd2, 4'd1}));
        en = 1'b0;
        repeat (10) @(negedge clk);

        // enable drops while a note is still held: the note is committed
        octave = 3'd6; key = 7'b0000100;
        en = 1'b1;
        wait_led("hold before en drop");
        repeat (8) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        key = '0;
        check("endrop track_len", 32'(track_len), 32'd1);
        check("endrop led", 32'(led), 32'd0);
        rd_addr = '0;
        @(negedge clk);
        check("endrop entry0", 32'(rd_data), 32'({3'd6, 3'd3, 4'd2}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
